slow_mem_responder: RTL and testbench
=====================================

// Module: slow_mem_responder
// PURPOSE
//  Responder end of the cache<->memory line protocol (mem_read/mem_write/mem_addr[31:4]/128b data/mem_ready).
//  Stands in for slow_memI / slow_memD: holds a line-addressed 128-bit RAM.
//  Answers each cache line request after a programmable latency with a one-cycle mem_ready pulse.
//  Flags protocol violations by the initiator.
// PARAMETERS
//  LATENCY     8    cycles from request acceptance to mem_ready pulse; legal range 1..255
//  DEPTH_LOG2  10   log2 of line count; index = mem_addr[DEPTH_LOG2+3:4], higher address bits alias
// PORTS
//  clk         in   1    single clock, rising edge
//  proc_reset  in   1    synchronous, active-high reset
//  mem_read    in   1    line read request, held by the initiator until mem_ready
//  mem_write   in   1    line write request, held by the initiator until mem_ready
//  mem_addr    in   28   line address [31:4]
//  mem_wdata   in   128  write line data
//  mem_rdata   out  128  read line data, valid only in the mem_ready cycle
//  mem_ready   out  1    one-cycle completion pulse
//  proto_err   out  1    sticky error flag, cleared only by reset
// BEHAVIOUR
//  Reset (proc_reset=1 at a clk edge):
//   - State goes to IDLE; mem_ready=0, mem_rdata=0, proto_err=0, counter=0.
//   - RAM contents are untouched.
//   - Reset asserted mid-BUSY aborts the access; a pending write is not committed.
//  FSM states: IDLE, BUSY, DONE.
//   - IDLE: if mem_read|mem_write is sampled high, latch op/addr/wdata, load counter=LATENCY-1, go to BUSY.
//   - BUSY, request still high: decrement the counter each cycle. When counter==0, perform the access and go to DONE with mem_ready=1.
//   - BUSY, request sampled low before counter==0: abort to IDLE. No write is committed, no ready is issued, proto_err is set.
//   - DONE: mem_ready=1 for exactly this cycle. Read: mem_rdata=RAM[idx]. Write: RAM[idx]<=latched wdata at the end of this cycle. Always go to IDLE.
//   - IDLE->IDLE: mem_rdata is held at 0 outside the ready cycle.
//  Latency: request first sampled at edge t means mem_ready is high in the cycle after edge t+LATENCY.
//   - Example: LATENCY=1 gives ready one cycle after acceptance.
//  Request dropped after mem_ready: the initiator drops its request on the edge that samples mem_ready.
//   - DONE->IDLE forces at least one idle cycle, so a request still high in that IDLE cycle is accepted as a new request.
//  Latched values:
//   - op/addr/wdata are latched at acceptance.
//   - mem_addr or mem_wdata changing during BUSY is ignored and sets proto_err.
//   - An op change between read and write during BUSY is also ignored and sets proto_err.
//  mem_read and mem_write both high at acceptance: treated as a write; proto_err is set; mem_rdata=0 in the ready cycle.
//  Read-after-write to the same line in back-to-back transactions returns the new data.
//  Counter width is 8 bits; LATENCY outside 1..255 is a compile-time error.
// STRUCTURE
//  Shared package mem_if_pkg: LINE_W=128, LINE_ADDR_W=28, state enum {IDLE,BUSY,DONE}.
//   - The same package serves the cache side of the protocol.
//  Sub-module slow_mem_array: single-port 2**DEPTH_LOG2 x 128 RAM.
//   - Synchronous write, asynchronous read.
//   - No reset on the array.
//  Top level contains the FSM, latency counter, request latches and error logic.
// TESTING
//  1. LATENCY=8, write addr=0x0000010 data=128'hA5..A5 held -> ready 8 cycles after accept, pulse width 1; then read the same addr -> rdata=A5..A5 in the ready cycle only.
//  2. Back-to-back reads: request held the cycle after ready -> exactly one idle cycle, then a second ready LATENCY cycles later; data correct per line.
//  3. mem_read and mem_write both =1, addr=0x3 -> write committed, rdata=0, proto_err=1 and stays 1 until reset.
//  4. Read dropped at counter=3 -> no ready pulse, FSM in IDLE, proto_err=1; a subsequent normal read -> correct data.
//  5. proc_reset pulsed mid-BUSY on a write -> outputs zero next cycle, line unchanged on readback.
//  6. Aliasing with DEPTH_LOG2=10: write addr=0x0000400 -> read addr=0x0000000 returns the same line; LATENCY=1 -> ready one cycle after accept.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared definitions for both ends of the cache<->memory line protocol.
package mem_if_pkg;

  localparam int LINE_W      = 128;
  localparam int LINE_ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/slow_mem_array.sv
// Line-addressed single-port RAM: synchronous write, asynchronous read, no reset.
module slow_mem_array
  import mem_if_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [LINE_W-1:0]     wdata,
  output logic [LINE_W-1:0]     rdata
);

  logic [LINE_W-1:0] mem_q [2**DEPTH_LOG2];

  // Write port: commits a full line on the clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/slow_mem_responder.sv
// Responder side of the cache<->memory line protocol: answers each held
// request after LATENCY cycles with a one-cycle mem_ready pulse and flags
// initiator protocol violations in a sticky proto_err.
module slow_mem_responder
  import mem_if_pkg::*;
#(
  parameter int LATENCY    = 8,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                   clk,
  input  logic                   proc_reset,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [LINE_ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]      mem_wdata,
  output logic [LINE_W-1:0]      mem_rdata,
  output logic                   mem_ready,
  output logic                   proto_err
);

  // The latency counter is 8 bits wide, so only 1..255 can be honoured.
  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("slow_mem_responder: LATENCY must be in 1..255");
  end

  mem_state_e             state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   op_wr_q, op_wr_d;
  logic [LINE_ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]      wdata_q, wdata_d;
  logic                   mem_ready_q, mem_ready_d;
  logic [LINE_W-1:0]      mem_rdata_q, mem_rdata_d;
  logic                   proto_err_q, proto_err_d;

  logic              req;
  logic              ram_we;
  logic [LINE_W-1:0] ram_rdata;

  assign req = mem_read | mem_write;

  // The write lands at the end of the DONE cycle; a reset on that edge wins.
  assign ram_we = (state_q == DONE) && op_wr_q && !proc_reset;

  slow_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .addr (addr_q[DEPTH_LOG2-1:0]),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // Next-state, latency countdown, request latching and violation detection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    proto_err_d = proto_err_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = '0;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          cnt_d   = 8'(LATENCY - 1);
          // Both strobes high resolves to a write and counts as a violation.
          op_wr_d = mem_write;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          if (mem_read && mem_write) begin
            proto_err_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          state_d     = IDLE;
          proto_err_d = 1'b1;
        end else begin
          if (mem_addr != addr_q || mem_wdata != wdata_q || mem_write != op_wr_q) begin
            proto_err_d = 1'b1;
          end
          if (cnt_q == 8'd0) begin
            state_d     = DONE;
            mem_ready_d = 1'b1;
            mem_rdata_d = op_wr_q ? '0 : ram_rdata;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      op_wr_q     <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Request address/data latches carry no reset; they are qualified by state.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_slow_mem_responder.sv
// Self-checking bench for slow_mem_responder: one instance at LATENCY=8 and
// one at LATENCY=1, selected by 'sel'; a line-indexed model tracks RAM state.
module tb_slow_mem_responder;

  localparam int L8 = 8;
  localparam int L1 = 1;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         rq_rd, rq_wr;
  logic [27:0]  rq_addr;
  logic [127:0] rq_wdata;
  logic         sel;

  logic         rd8, wr8, rd1, wr1;
  logic [127:0] rdata8, rdata1, rdata;
  logic         rdy8, rdy1, rdy;
  logic         err8, err1, err;

  int checks   = 0;
  int failures = 0;

  logic [127:0] mdl [int];

  always #5 clk = ~clk;

  assign rd8   = sel ? 1'b0 : rq_rd;
  assign wr8   = sel ? 1'b0 : rq_wr;
  assign rd1   = sel ? rq_rd : 1'b0;
  assign wr1   = sel ? rq_wr : 1'b0;
  assign rdy   = sel ? rdy1 : rdy8;
  assign rdata = sel ? rdata1 : rdata8;
  assign err   = sel ? err1 : err8;

  slow_mem_responder #(.LATENCY(L8), .DEPTH_LOG2(10)) dut8 (
    .clk(clk), .proc_reset(proc_reset), .mem_read(rd8), .mem_write(wr8),
    .mem_addr(rq_addr), .mem_wdata(rq_wdata), .mem_rdata(rdata8),
    .mem_ready(rdy8), .proto_err(err8)
  );

  slow_mem_responder #(.LATENCY(L1), .DEPTH_LOG2(10)) dut1 (
    .clk(clk), .proc_reset(proc_reset), .mem_read(rd1), .mem_write(wr1),
    .mem_addr(rq_addr), .mem_wdata(rq_wdata), .mem_rdata(rdata1),
    .mem_ready(rdy1), .proto_err(err1)
  );

  typedef struct {
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    rq_rd = 1'b0;
    rq_wr = 1'b0;
    repeat (2) @(negedge clk);
    proc_reset = 1'b0;
  endtask

  // Counts edges from the caller's negedge until mem_ready is observed.
  task automatic wait_ready(output int edges, output logic [127:0] rd_o);
    bit done;
    edges = 0;
    rd_o  = '0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      edges++;
      if (rdy) begin
        rd_o = rdata;
        done = 1'b1;
      end else if (edges >= 400) begin
        checks++;
        failures++;
        $display("FAIL ready_timeout got=none exp=ready");
        done = 1'b1;
      end
    end
  endtask

  // One complete transaction issued from an idle responder, with latency,
  // data, pulse-width and post-pulse rdata checks.
  task automatic run(input string name, input logic rd, input logic wr,
                     input logic [27:0] a, input logic [127:0] d,
                     input logic [127:0] exp, input bit hold);
    int           edges;
    logic [127:0] got;
    int           lat;
    lat      = sel ? L1 : L8;
    rq_rd    = rd;
    rq_wr    = wr;
    rq_addr  = a;
    rq_wdata = d;
    wait_ready(edges, got);
    check({name, "_lat"}, 128'(edges), 128'(lat + 1));
    check({name, "_rdata"}, got, exp);
    if (!hold) begin
      rq_rd = 1'b0;
      rq_wr = 1'b0;
    end
    @(negedge clk);
    check({name, "_pulse"}, {127'd0, rdy}, 128'd0);
    check({name, "_rdata_idle"}, rdata, 128'd0);
    if (wr) mdl[int'(a[9:0])] = d;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl [8];
    logic [127:0] a5, v1, v2, got;
    logic [27:0]  a;
    int           edges;
    bit           saw;

    sel        = 1'b0;
    rq_rd      = 1'b0;
    rq_wr      = 1'b0;
    rq_addr    = '0;
    rq_wdata   = '0;
    proc_reset = 1'b1;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_ready", {127'd0, rdy}, 128'd0);
    check("rst_rdata", rdata, 128'd0);
    check("rst_err", {127'd0, err}, 128'd0);

    // Write A5 pattern then read it back
    a5 = {16{8'hA5}};
    run("t1_wr", 1'b0, 1'b1, 28'h0000010, a5, 128'd0, 1'b0);
    run("t1_rd", 1'b1, 1'b0, 28'h0000010, '0, a5, 1'b0);

    // Table-driven writes, readbacks and read-after-write
    tbl[0] = '{1'b0, 1'b1, 28'h0000020, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'd0};
    tbl[1] = '{1'b0, 1'b1, 28'h0000021, 128'hDEAD_BEEF_0000_0001_FFFF_FFFF_0000_0000, 128'd0};
    tbl[2] = '{1'b0, 1'b1, 28'h00003FF, {4{32'hCAFE_F00D}}, 128'd0};
    tbl[3] = '{1'b1, 1'b0, 28'h0000020, '0, 128'h1111_2222_3333_4444_5555_6666_7777_8888};
    tbl[4] = '{1'b1, 1'b0, 28'h0000021, '0, 128'hDEAD_BEEF_0000_0001_FFFF_FFFF_0000_0000};
    tbl[5] = '{1'b1, 1'b0, 28'h00003FF, '0, {4{32'hCAFE_F00D}}};
    tbl[6] = '{1'b0, 1'b1, 28'h0000020, {128{1'b1}}, 128'd0};
    tbl[7] = '{1'b1, 1'b0, 28'h0000020, '0, {128{1'b1}}};
    for (int i = 0; i < 8; i++) begin
      run($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp, 1'b0);
    end

    // Back-to-back reads: request held through the idle cycle
    run("t2_first", 1'b1, 1'b0, 28'h0000021, '0, 128'hDEAD_BEEF_0000_0001_FFFF_FFFF_0000_0000, 1'b1);
    run("t2_second", 1'b1, 1'b0, 28'h00003FF, '0, {4{32'hCAFE_F00D}}, 1'b0);

    // Randomised traffic on 8 lines with aliasing upper address bits
    for (int i = 0; i < 8; i++) begin
      v1 = rnd128();
      run("rnd_init", 1'b0, 1'b1, {18'($urandom), 10'(12'h100 + i)}, v1, 128'd0, 1'b0);
    end
    for (int i = 0; i < 30; i++) begin
      a = {18'($urandom), 10'(12'h100 + $urandom_range(0, 7))};
      if ($urandom_range(0, 1) == 1) begin
        run("rnd_wr", 1'b0, 1'b1, a, rnd128(), 128'd0, 1'b0);
      end else begin
        run("rnd_rd", 1'b1, 1'b0, a, '0, mdl[int'(a[9:0])], 1'b0);
      end
    end
    check("clean_err", {127'd0, err}, 128'd0);

    // Address changed mid-BUSY is ignored and flagged
    v1 = rnd128();
    v2 = rnd128();
    run("chg_preB", 1'b0, 1'b1, 28'h0000051, v2, 128'd0, 1'b0);
    rq_wr = 1'b1; rq_addr = 28'h0000050; rq_wdata = v1;
    repeat (2) @(negedge clk);
    rq_addr = 28'h0000051;
    wait_ready(edges, got);
    rq_wr = 1'b0;
    @(negedge clk);
    check("chg_err", {127'd0, err}, 128'd1);
    run("chg_rdA", 1'b1, 1'b0, 28'h0000050, '0, v1, 1'b0);
    run("chg_rdB", 1'b1, 1'b0, 28'h0000051, '0, v2, 1'b0);
    do_reset();

    // Read and write both high: treated as write, flagged, sticky
    v1 = rnd128();
    run("t3_both", 1'b1, 1'b1, 28'h0000003, v1, 128'd0, 1'b0);
    check("t3_err", {127'd0, err}, 128'd1);
    run("t3_rd", 1'b1, 1'b0, 28'h0000003, '0, v1, 1'b0);
    check("t3_err_sticky", {127'd0, err}, 128'd1);
    do_reset();
    check("t3_err_rst", {127'd0, err}, 128'd0);

    // Read dropped at counter 3: no pulse, error, recovery
    rq_rd = 1'b1; rq_addr = 28'h0000010;
    repeat (5) @(negedge clk);
    rq_rd = 1'b0;
    @(negedge clk);
    check("t4_err", {127'd0, err}, 128'd1);
    saw = rdy;
    repeat (12) begin
      @(negedge clk);
      if (rdy) saw = 1'b1;
    end
    check("t4_no_ready", {127'd0, saw}, 128'd0);
    run("t4_rd", 1'b1, 1'b0, 28'h0000010, '0, a5, 1'b0);
    do_reset();

    // Reset mid-BUSY on a write: nothing committed
    rq_wr = 1'b1; rq_addr = 28'h0000010; rq_wdata = rnd128();
    repeat (3) @(negedge clk);
    proc_reset = 1'b1; rq_wr = 1'b0;
    @(negedge clk);
    check("t5_ready", {127'd0, rdy}, 128'd0);
    check("t5_rdata", rdata, 128'd0);
    check("t5_err", {127'd0, err}, 128'd0);
    proc_reset = 1'b0;
    repeat (12) @(negedge clk);
    run("t5_rd", 1'b1, 1'b0, 28'h0000010, '0, a5, 1'b0);

    // Aliasing and minimum latency on the LATENCY=1 instance
    sel = 1'b1;
    @(negedge clk);
    v1 = rnd128();
    run("t6_wr", 1'b0, 1'b1, 28'h0000400, v1, 128'd0, 1'b0);
    run("t6_rd", 1'b1, 1'b0, 28'h0000000, '0, v1, 1'b0);
    check("t6_err", {127'd0, err}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
